// File: rtl/fpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fpu_ctrl_pkg
// Shared definitions for the FP issue sequencer: opcode field positions,
// sequencer state encoding, error codes, the canonical quiet NaN returned on
// error, and the opcode legality check.
// -----------------------------------------------------------------------------
package fpu_ctrl_pkg;

  // Opcode layout: bit 0 is the modifier (sub/neg), bits 4:1 one-hot unit select.
  localparam int OP_W      = 5;
  localparam int OP_MOD    = 0;
  localparam int OP_SEL_LO = 1;
  localparam int OP_SEL_HI = 4;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [4:0]  FLAG_NV = 5'b10000;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  // Legal when exactly one unit-select bit is set; the modifier bit is free.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    logic [OP_SEL_HI-OP_SEL_LO:0] sel;
    sel = op[OP_SEL_HI:OP_SEL_LO];
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

  function automatic logic op_is_mod(input logic [OP_W-1:0] op);
    return op[OP_MOD];
  endfunction

endpackage

// File: rtl/fpu_issue_sequencer_if.sv
// -----------------------------------------------------------------------------
// fpu_issue_sequencer_if
// Bundles the three channels around the sequencer:
//   req_*  front end -> sequencer request (valid/ready)
//   alu_*  sequencer <-> ALU (start pulse, held operands, done pulse)
//   rsp_*  sequencer -> consumer response (valid/ready)
// Handshake rule for req and rsp: a transfer happens on a rising clock edge
// where valid and ready are both 1; once valid is raised the payload stays
// stable until that transfer, and valid never depends combinationally on ready.
// modport slave is the sequencer side, modport master the environment side.
// -----------------------------------------------------------------------------
interface fpu_issue_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_opcode;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             alu_start;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic [4:0]       alu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [4:0]       rsp_flags;
  logic [1:0]       rsp_err;
  logic [4:0]       rsp_opcode;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b,
    output req_ready,
    output alu_start, alu_op, alu_a, alu_b,
    input  alu_done, alu_result, alu_flags,
    output rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_opcode,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b,
    input  req_ready,
    input  alu_start, alu_op, alu_a, alu_b,
    output alu_done, alu_result, alu_flags,
    input  rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_opcode,
    output rsp_ready
  );

endinterface

// File: rtl/fpu_watchdog.sv
// -----------------------------------------------------------------------------
// fpu_watchdog
// Counts cycles while enabled and flags the last allowed cycle.
//   clk, rst_n  clock / async active-low reset
//   clear       zero the counter (has priority over enable)
//   enable      count this cycle
//   expired     1 while enabled and the count has reached TIMEOUT-1, i.e. in
//               the TIMEOUT-th enabled cycle after a clear
// -----------------------------------------------------------------------------
module fpu_watchdog #(
  parameter  int TIMEOUT = 64,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/fpu_issue_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_issue_sequencer
// Single-issue sequencer between the instruction front end and the FP ALU.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   bus          fpu_issue_sequencer_if.slave: req_* request channel, alu_*
//                ALU drive/return, rsp_* response channel
//   state        current sequencer state (debug visibility)
// Flow: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, or IDLE -> RESP for an illegal
// opcode. All outputs are registered; only one operation is ever in flight.
// -----------------------------------------------------------------------------
module fpu_issue_sequencer
  import fpu_ctrl_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int TIMEOUT = 64,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  fpu_issue_sequencer_if.slave         bus,
  output seq_state_t                   state
);

  logic wd_expired;

  // Cleared during ISSUE so the first WAIT cycle sees a count of zero.
  fpu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ISSUE),
    .enable  (state == WAIT),
    .expired (wd_expired)
  );

  // alu_op/a/b double as the captured request registers; they are zeroed on
  // leaving WAIT so the ALU sees a quiet bus outside ISSUE..WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.alu_start  <= 1'b0;
      bus.alu_op     <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_err    <= '0;
      bus.rsp_opcode <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            if (op_legal(bus.req_opcode)) begin
              state         <= ISSUE;
              bus.alu_start <= 1'b1;
              bus.alu_op    <= bus.req_opcode;
              bus.alu_a     <= bus.req_a;
              bus.alu_b     <= bus.req_b;
            end else begin
              state          <= RESP;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_result <= WIDTH'(QNAN);
              bus.rsp_flags  <= FLAG_NV;
              bus.rsp_err    <= ERR_ILLEGAL;
              bus.rsp_opcode <= bus.req_opcode;
            end
          end
        end

        ISSUE: begin
          bus.alu_start <= 1'b0;
          state         <= WAIT;
        end

        WAIT: begin
          // done is tested first so a done in the expiring cycle still wins.
          if (bus.alu_done || wd_expired) begin
            state          <= RESP;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_opcode <= bus.alu_op;
            bus.alu_op     <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            if (bus.alu_done) begin
              bus.rsp_result <= bus.alu_result;
              bus.rsp_flags  <= bus.alu_flags;
              bus.rsp_err    <= ERR_OK;
            end else begin
              bus.rsp_result <= WIDTH'(QNAN);
              bus.rsp_flags  <= FLAG_NV;
              bus.rsp_err    <= ERR_TIMEOUT;
            end
          end
        end

        RESP: begin
          // req_ready only rises next cycle: no accept in the retire cycle.
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_sequencer
// Two sequencers share clock and reset: u_dut (TIMEOUT=8) carries most
// scenarios, u_dut4 (TIMEOUT=4) the done-on-expiry boundary. Stimulus and
// ALU returns are driven on the falling edge; response monitors pop the
// expected queues when a response handshake is presented.
// -----------------------------------------------------------------------------
module tb_fpu_issue_sequencer;
  import fpu_ctrl_pkg::*;

  localparam int WIDTH = 32;
  localparam int RW    = WIDTH + 12;

  logic       clk;
  logic       rst_n;
  seq_state_t state;
  seq_state_t state4;

  fpu_issue_sequencer_if #(.WIDTH(WIDTH)) bus ();
  fpu_issue_sequencer_if #(.WIDTH(WIDTH)) bus4 ();

  fpu_issue_sequencer #(.WIDTH(WIDTH), .TIMEOUT(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  fpu_issue_sequencer #(.WIDTH(WIDTH), .TIMEOUT(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4),
    .state (state4)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp4_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.alu_start) starts++;
  end

  // Monitors: sampled just after the falling edge, where inputs for the next
  // rising edge are already settled.
  always @(negedge clk) begin : mon_main
    logic [RW-1:0] e;
    #1;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=%h required=none",
                 {bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.rsp_opcode});
      end else begin
        e = exp_q.pop_front();
        check("rsp", {bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.rsp_opcode}, e);
      end
    end
  end

  always @(negedge clk) begin : mon_t4
    logic [RW-1:0] e;
    #1;
    if (rst_n && bus4.rsp_valid && bus4.rsp_ready) begin
      if (exp4_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp4_unexpected actual=%h required=none",
                 {bus4.rsp_result, bus4.rsp_flags, bus4.rsp_err, bus4.rsp_opcode});
      end else begin
        e = exp4_q.pop_front();
        check("rsp4", {bus4.rsp_result, bus4.rsp_flags, bus4.rsp_err, bus4.rsp_opcode}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns on the falling edge of the cycle after acceptance (ISSUE or RESP).
  task automatic send_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_send", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_a      = a;
    bus.req_b      = b;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  task automatic alu_return(input logic [31:0] res, input logic [4:0] flg);
    bus.alu_done   = 1'b1;
    bus.alu_result = res;
    bus.alu_flags  = flg;
    @(negedge clk);
    bus.alu_done   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] ill [4];
  int s0;
  int n;

  initial begin
    ill[0] = 5'b00110;
    ill[1] = 5'b00001;
    ill[2] = 5'b00000;
    ill[3] = 5'b11111;

    rst_n = 1'b0;
    bus.req_valid = 1'b0;  bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0;
    bus.alu_done = 1'b0;   bus.alu_result = '0; bus.alu_flags = '0;
    bus.rsp_ready = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_opcode = '0; bus4.req_a = '0; bus4.req_b = '0;
    bus4.alu_done = 1'b0;  bus4.alu_result = '0; bus4.alu_flags = '0;
    bus4.rsp_ready = 1'b1;

    #12;
    check("reset_outputs",
          {bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_valid,
           bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.rsp_opcode}, 0);
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_state", state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: add, done three cycles after start
    s0 = starts;
    exp_q.push_back({32'h4040_0000, 5'b00001, ERR_OK, 5'b00010});
    send_req(5'b00010, 32'h3F80_0000, 32'h4000_0000);
    check("add_start", bus.alu_start, 1);
    check("add_alu_bus", {bus.alu_op, bus.alu_a, bus.alu_b},
          {5'b00010, 32'h3F80_0000, 32'h4000_0000});
    check("add_busy_not_ready", bus.req_ready, 0);
    repeat (2) @(negedge clk);
    check("add_start_one_cycle", bus.alu_start, 0);
    check("add_op_held", bus.alu_op, 5'b00010);
    check("add_state_wait", state, WAIT);
    @(negedge clk);
    alu_return(32'h4040_0000, 5'b00001);
    check("add_rsp_latency", bus.rsp_valid, 1);
    check("add_alu_op_cleared", bus.alu_op, 0);
    @(negedge clk);
    check("add_back_idle", {state, bus.req_ready, bus.rsp_valid}, {IDLE, 1'b1, 1'b0});
    check("add_start_count", starts - s0, 1);

    // 2: illegal opcodes, answered the cycle after accept without the ALU
    for (int i = 0; i < 4; i++) begin
      s0 = starts;
      exp_q.push_back({QNAN, FLAG_NV, ERR_ILLEGAL, ill[i]});
      send_req(ill[i], 32'h1111_0000 + i, 32'h2222_0000);
      check("ill_rsp_next_cycle", bus.rsp_valid, 1);
      check("ill_no_start", bus.alu_start, 0);
      @(negedge clk);
      check("ill_back_idle", state, IDLE);
      check("ill_start_count", starts - s0, 0);
    end

    // 3: timeout after 8 WAIT cycles, late done ignored
    exp_q.push_back({QNAN, FLAG_NV, ERR_TIMEOUT, 5'b01000});
    send_req(5'b01000, 32'hAAAA_0001, 32'hBBBB_0002);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, 9);
    @(negedge clk);
    check("timeout_back_idle", state, IDLE);
    alu_return(32'hDEAD_BEEF, 5'b00011);
    check("late_done_ignored", {state, bus.rsp_valid}, {IDLE, 1'b0});
    @(negedge clk);
    check("late_done_no_rsp", bus.rsp_valid, 0);

    // 4: response backpressure for five cycles
    bus.rsp_ready = 1'b0;
    exp_q.push_back({32'hC0A0_0000, 5'b00100, ERR_OK, 5'b00101});
    send_req(5'b00101, 32'h4000_0000, 32'h40E0_0000);
    @(negedge clk);
    alu_return(32'hC0A0_0000, 5'b00100);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold",
            {bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.rsp_opcode},
            {1'b1, 1'b0, 32'hC0A0_0000, 5'b00100, ERR_OK, 5'b00101});
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", {state, bus.req_ready, bus.rsp_valid}, {IDLE, 1'b1, 1'b0});

    // 5: asynchronous reset in WAIT, then a normal op
    send_req(5'b10000, 32'h1234_5678, 32'h8765_4321);
    @(negedge clk);
    check("rst_pre_wait", state, WAIT);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_valid,
           bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.rsp_opcode}, 0);
    check("rst_async_ready_state", {bus.req_ready, state}, {1'b1, IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({32'h3F00_0000, 5'b00000, ERR_OK, 5'b10001});
    send_req(5'b10001, 32'h3F80_0000, 32'h3F00_0000);
    repeat (2) @(negedge clk);
    alu_return(32'h3F00_0000, 5'b00000);
    check("post_rst_rsp", bus.rsp_valid, 1);
    @(negedge clk);

    // 6: TIMEOUT=4 instance, done in the 4th WAIT cycle wins over expiry
    exp4_q.push_back({32'h4120_0000, 5'b00001, ERR_OK, 5'b00100});
    @(negedge clk);
    bus4.req_valid = 1'b1; bus4.req_opcode = 5'b00100;
    bus4.req_a = 32'h4000_0000; bus4.req_b = 32'h40A0_0000;
    @(negedge clk);
    bus4.req_valid = 1'b0;
    check("t4_start", bus4.alu_start, 1);
    repeat (4) @(negedge clk);
    check("t4_fourth_wait", state4, WAIT);
    bus4.alu_done = 1'b1; bus4.alu_result = 32'h4120_0000; bus4.alu_flags = 5'b00001;
    @(negedge clk);
    bus4.alu_done = 1'b0;
    check("t4_done_wins", {bus4.rsp_valid, bus4.rsp_err}, {1'b1, ERR_OK});
    @(negedge clk);

    // TIMEOUT=4 with no done: response after exactly 4 WAIT cycles
    exp4_q.push_back({QNAN, FLAG_NV, ERR_TIMEOUT, 5'b10000});
    bus4.req_valid = 1'b1; bus4.req_opcode = 5'b10000;
    @(negedge clk);
    bus4.req_valid = 1'b0;
    n = 0;
    while (!bus4.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_latency", n, 5);

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp4_q_drained", exp4_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
